// File: rtl/ddr_writer_pkg.sv
// ddr_writer_pkg: shared FSM state type and address-geometry helpers for the DDR sample burst writer.
package ddr_writer_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int unsigned bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int unsigned burst_stride(input int burst_len, input int data_w);
    return burst_len * bytes_per_word(data_w);
  endfunction
  function automatic logic [63:0] ring_end(input logic [63:0] base, input int ring_words, input int data_w);
    return base + 64'(ring_words) * 64'(bytes_per_word(data_w));
  endfunction
endpackage

// File: rtl/ddr_sample_burst_writer_if.sv
// ddr_sample_burst_writer_if: Avalon-MM burst write port between the sample writer and the memory subsystem.
interface ddr_sample_burst_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 8
);
  logic [ADDR_W-1:0] avm_address;
  logic avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [$clog2(BURST_LEN):0] avm_burstcount;
  logic avm_waitrequest;
  modport master (output avm_address, avm_write, avm_writedata, avm_burstcount, input avm_waitrequest);
  modport slave (input avm_address, avm_write, avm_writedata, avm_burstcount, output avm_waitrequest);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: show-ahead synchronous FIFO; dout is the head word, or zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
endmodule

// File: rtl/ddr_sample_burst_writer.sv
// ddr_sample_burst_writer: stages a free-running sample stream in a FIFO and writes it to a DDR ring buffer
// as fixed-length Avalon-MM bursts.
module ddr_sample_burst_writer
  import ddr_writer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 8,
  parameter int FIFO_DEPTH = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int RING_WORDS = 4096
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic enable,
  input  logic clear_ovf,
  input  logic [DATA_W-1:0] sample_data,
  input  logic sample_valid,
  ddr_sample_burst_writer_if.master avm,
  output logic overflow,
  output logic [15:0] wrap_count,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(burst_stride(BURST_LEN, DATA_W));
  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(ring_end(64'(BASE_ADDR), RING_WORDS, DATA_W));
  state_t state, state_nx;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] ptr, ptr_adv;
  logic pop, push, full, empty, last;
  assign pop = avm.avm_write && !avm.avm_waitrequest && !empty;
  // a full FIFO still takes a sample when the head is leaving on the same edge
  assign push = sample_valid && (!full || pop);
  assign last = pop && beat == BW'(BURST_LEN - 1);
  assign ptr_adv = ptr + STRIDE;
  sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst_n(reset_reset_n),
    .push(push),
    .pop(pop),
    .din(sample_data),
    .dout(avm.avm_writedata),
    .full(full),
    .empty(empty),
    .count(fill_level)
  );
  always_ff @(posedge clk_clk) state <= !reset_reset_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? ((enable && fill_level >= CW'(BURST_LEN)) ? BURST : IDLE)
                             : (last ? IDLE : BURST);
  end
  always_comb begin
    avm.avm_write = state == BURST;
    avm.avm_address = ptr;
    avm.avm_burstcount = (BW + 1)'(BURST_LEN);
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      beat <= '0;
      ptr <= BASE_ADDR;
      wrap_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) beat <= beat + BW'(1);
      if (last) ptr <= ptr_adv == END_ADDR ? BASE_ADDR : ptr_adv;
      if (last && ptr_adv == END_ADDR) wrap_count <= wrap_count + 16'd1;
      overflow <= clear_ovf ? 1'b0 : (overflow || (sample_valid && !push));
    end
  end
endmodule

// File: tb/tb_ddr_sample_burst_writer.sv
// tb_ddr_sample_burst_writer: scenario tests plus a queue-based reference model checked every cycle.
module tb_ddr_sample_burst_writer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 8;
  localparam int FD = 32;
  localparam int RW = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STRIDE = BL * DW / 8;
  localparam logic [31:0] RING_END = BASE + RW * DW / 8;

  logic clk = 1'b0;
  logic rst_n, enable, clear_ovf, sample_valid, overflow;
  logic [DW-1:0] sample_data;
  logic [15:0] wrap_count;
  logic [5:0] fill_level;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_sample_burst_writer_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)) bus ();

  ddr_sample_burst_writer #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD), .BASE_ADDR(BASE), .RING_WORDS(RW)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .enable(enable),
    .clear_ovf(clear_ovf),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .avm(bus),
    .overflow(overflow),
    .wrap_count(wrap_count),
    .fill_level(fill_level)
  );

  // reference model: buffered samples, burst progress, ring pointer, flags
  logic [31:0] m_q[$];
  bit m_busy;
  int m_beat;
  logic [31:0] m_ptr;
  int m_wrap;
  bit m_ovf;
  int cyc = 0;
  logic [31:0] beat_data[$];
  logic [31:0] beat_addr[$];
  int beat_cyc[$];

  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic w, input logic e, input logic c);
    bit pop, push, start;
    int n;
    rst_n = r;
    sample_valid = v;
    sample_data = d;
    bus.avm_waitrequest = w;
    enable = e;
    clear_ovf = c;
    n = m_q.size();
    pop = r && m_busy && !w;
    push = r && v && (n < FD || pop);
    start = r && !m_busy && e && n >= BL;
    if (pop) begin
      beat_data.push_back(bus.avm_writedata);
      beat_addr.push_back(bus.avm_address);
      beat_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!r) begin
      m_q.delete();
      m_busy = 0;
      m_beat = 0;
      m_ptr = BASE;
      m_wrap = 0;
      m_ovf = 0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_beat++;
      end
      if (push) m_q.push_back(d);
      m_ovf = c ? 1'b0 : (m_ovf || (v && !push));
      if (pop && m_beat == BL) begin
        m_busy = 0;
        m_beat = 0;
        m_ptr = m_ptr + STRIDE;
        if (m_ptr == RING_END) begin
          m_ptr = BASE;
          m_wrap++;
        end
      end else if (start) begin
        m_busy = 1;
        m_beat = 0;
      end
    end
    checks++;
    if (bus.avm_write !== m_busy) begin
      failures++;
      $display("FAIL avm_write cyc=%0d got=%b exp=%b", cyc, bus.avm_write, m_busy);
    end
    checks++;
    if (fill_level !== 6'(m_q.size())) begin
      failures++;
      $display("FAIL fill_level cyc=%0d got=%0d exp=%0d", cyc, fill_level, m_q.size());
    end
    checks++;
    if (overflow !== m_ovf) begin
      failures++;
      $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
    end
    checks++;
    if (wrap_count !== 16'(m_wrap)) begin
      failures++;
      $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, wrap_count, m_wrap);
    end
    if (m_busy) begin
      checks++;
      if (bus.avm_address !== m_ptr || bus.avm_burstcount !== 4'(BL)) begin
        failures++;
        $display("FAIL burst_hdr cyc=%0d got=%h/%0d exp=%h/%0d", cyc, bus.avm_address, bus.avm_burstcount, m_ptr, BL);
      end
    end
    if (m_q.size() > 0) begin
      checks++;
      if (bus.avm_writedata !== m_q[0]) begin
        failures++;
        $display("FAIL writedata cyc=%0d got=%h exp=%h", cyc, bus.avm_writedata, m_q[0]);
      end
    end
  endtask

  task automatic do_reset;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    beat_data.delete();
    beat_addr.delete();
    beat_cyc.delete();
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 32'hA5A5_0000 + i, 0, 0, 0);
    step(0, 1, 32'hDEAD_BEEF, 0, 1, 0);
    checks++;
    if (bus.avm_write !== 1'b0 || bus.avm_address !== BASE || bus.avm_burstcount !== 4'd8 || bus.avm_writedata !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus got=%b/%h/%0d/%h exp=0/%h/8/0", bus.avm_write, bus.avm_address, bus.avm_burstcount, bus.avm_writedata, BASE);
    end
    checks++;
    if (overflow !== 1'b0 || wrap_count !== 16'd0 || fill_level !== 6'd0) begin
      failures++;
      $display("FAIL reset_status got=%b/%0d/%0d exp=0/0/0", overflow, wrap_count, fill_level);
    end
  endtask

  task automatic test_stream;
    int k = 0;
    int n = 0;
    do_reset();
    while (beat_data.size() < 16 && n < 80) begin
      step(1, 1, k, 0, 1, 0);
      k++;
      n++;
    end
    checks++;
    if (beat_data.size() < 16) begin
      failures++;
      $display("FAIL stream_timeout got=%0d beats exp=16", beat_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (beat_data[i] !== 32'(i) || beat_addr[i] !== (i < 8 ? BASE : BASE + 32)) begin
          failures++;
          $display("FAIL stream_beat%0d got=%h@%h exp=%h@%h", i, beat_data[i], beat_addr[i], i, i < 8 ? BASE : BASE + 32);
        end
      end
      checks++;
      if (beat_cyc[7] - beat_cyc[0] != 7 || beat_cyc[8] - beat_cyc[7] != 2) begin
        failures++;
        $display("FAIL stream_timing got=%0d/%0d exp=7/2", beat_cyc[7] - beat_cyc[0], beat_cyc[8] - beat_cyc[7]);
      end
    end
  endtask

  task automatic test_stall;
    int k = 0;
    int n = 0;
    int stall = 0;
    logic w;
    do_reset();
    while (beat_data.size() < 8 && n < 80) begin
      w = m_busy && m_beat == 3 && stall < 5;
      if (w) stall++;
      step(1, k < 8, k, w, 1, 0);
      if (k < 8) k++;
      n++;
      if (w) begin
        checks++;
        if (bus.avm_writedata !== 32'd3 || bus.avm_address !== BASE || bus.avm_burstcount !== 4'd8 || fill_level !== 6'd5) begin
          failures++;
          $display("FAIL stall_hold got=%h/%h/%0d/%0d exp=3/%h/8/5", bus.avm_writedata, bus.avm_address, bus.avm_burstcount, fill_level, BASE);
        end
      end
    end
    checks++;
    if (beat_data.size() < 8 || stall != 5) begin
      failures++;
      $display("FAIL stall_timeout got=%0d beats %0d stalls exp=8/5", beat_data.size(), stall);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (beat_data[i] !== 32'(i)) begin
          failures++;
          $display("FAIL stall_beat%0d got=%h exp=%h", i, beat_data[i], i);
        end
      end
      checks++;
      if (beat_cyc[3] - beat_cyc[2] != 6 || beat_cyc[4] - beat_cyc[3] != 1) begin
        failures++;
        $display("FAIL stall_gap got=%0d/%0d exp=6/1", beat_cyc[3] - beat_cyc[2], beat_cyc[4] - beat_cyc[3]);
      end
    end
  endtask

  task automatic test_overflow;
    int n = 0;
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 1, i, 0, 0, 0);
    checks++;
    if (fill_level !== 6'd32 || overflow !== 1'b1 || bus.avm_writedata !== 32'd0) begin
      failures++;
      $display("FAIL ovf_fill got=%0d/%b/%h exp=32/1/0", fill_level, overflow, bus.avm_writedata);
    end
    step(1, 1, 999, 0, 0, 1);
    checks++;
    if (overflow !== 1'b0 || fill_level !== 6'd32) begin
      failures++;
      $display("FAIL ovf_clear got=%b/%0d exp=0/32", overflow, fill_level);
    end
    while (beat_data.size() < 32 && n < 100) begin
      step(1, 0, 0, 0, 1, 0);
      n++;
    end
    checks++;
    if (beat_data.size() < 32) begin
      failures++;
      $display("FAIL ovf_drain got=%0d beats exp=32", beat_data.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (beat_data[i] !== 32'(i)) begin
          failures++;
          $display("FAIL ovf_beat%0d got=%h exp=%h", i, beat_data[i], i);
        end
      end
    end
  endtask

  task automatic test_wrap;
    int k = 0;
    int n = 0;
    bit seen = 0;
    do_reset();
    while (beat_data.size() < 40 && n < 120) begin
      step(1, k < 40, k, 0, 1, 0);
      if (k < 40) k++;
      n++;
      if (beat_data.size() == 32 && !seen) begin
        seen = 1;
        checks++;
        if (wrap_count !== 16'd2) begin
          failures++;
          $display("FAIL wrap_after4 got=%0d exp=2", wrap_count);
        end
      end
    end
    checks++;
    if (beat_data.size() < 40) begin
      failures++;
      $display("FAIL wrap_timeout got=%0d beats exp=40", beat_data.size());
    end else begin
      for (int b = 0; b < 5; b++) begin
        checks++;
        if (beat_addr[b*8] !== (b % 2 == 1 ? BASE + 32 : BASE) || beat_data[b*8+7] !== 32'(b*8+7)) begin
          failures++;
          $display("FAIL wrap_burst%0d got=%h/%h exp=%h/%h", b, beat_addr[b*8], beat_data[b*8+7], b % 2 == 1 ? BASE + 32 : BASE, b*8+7);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int k = 100;
    int n = 0;
    do_reset();
    while (!(m_busy && m_beat == 4) && n < 60) begin
      step(1, 1, k, 0, 1, 0);
      k++;
      n++;
    end
    step(0, 1, k, 0, 1, 0);
    checks++;
    if (n >= 60 || bus.avm_write !== 1'b0 || fill_level !== 6'd0 || bus.avm_address !== BASE) begin
      failures++;
      $display("FAIL midreset got=%b/%0d/%h n=%0d exp=0/0/%h", bus.avm_write, fill_level, bus.avm_address, n, BASE);
    end
    beat_data.delete();
    beat_addr.delete();
    beat_cyc.delete();
    k = 200;
    n = 0;
    while (beat_data.size() < 8 && n < 60) begin
      step(1, k < 208, k, 0, 1, 0);
      if (k < 208) k++;
      n++;
    end
    checks++;
    if (beat_data.size() < 8) begin
      failures++;
      $display("FAIL midreset_timeout got=%0d beats exp=8", beat_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (beat_data[i] !== 32'(200 + i) || beat_addr[i] !== BASE) begin
          failures++;
          $display("FAIL midreset_beat%0d got=%h@%h exp=%h@%h", i, beat_data[i], beat_addr[i], 200 + i, BASE);
        end
      end
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 500; i++)
      step(1, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) != 0, $urandom_range(0, 19) == 0);
    checks++;
    if (beat_data.size() < 64) begin
      failures++;
      $display("FAIL random_progress got=%0d beats exp>=64", beat_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ddr_sample_burst_writer.md
# ddr_sample_burst_writer

Captures the receiver's demodulated sample stream into a circular buffer in the DDR3 SDRAM behind the receiver Qsys system. Sits directly upstream of the Qsys memory subsystem and masters an Avalon-MM burst write port on it. Samples arrive as unthrottled valid strobes and are staged in an internal FIFO. Fixed-length bursts are issued whenever a full burst is buffered.

## Interface
Parameters:
- DATA_W, 32, sample/word width; byte-lane count = DATA_W/8
- ADDR_W, 32, Avalon byte address width
- BURST_LEN, 8, words per burst; power of two, 2..64
- FIFO_DEPTH, 32, staging FIFO words; power of two, ≥ 2·BURST_LEN
- BASE_ADDR, 32'h0000_0000, ring start byte address; aligned to BURST_LEN·DATA_W/8
- RING_WORDS, 4096, ring size in words; multiple of BURST_LEN

Ports:
- clk_clk  in  1  single clock; reset is synchronous and active-low
- reset_reset_n  in  1  synchronous active-low reset
- enable  in  1  level; permits new bursts to start
- clear_ovf  in  1  one-cycle pulse; clears overflow
- sample_data  in  DATA_W  sample word
- sample_valid  in  1  sample_data valid this cycle; no backpressure
- avm_address  out  ADDR_W  burst start byte address
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  beat data
- avm_burstcount  out  $clog2(BURST_LEN)+1  always BURST_LEN while avm_write is high
- avm_waitrequest  in  1  slave stall
- overflow  out  1  sticky: a sample was dropped
- wrap_count  out  16  completed ring passes, wraps modulo 2^16
- fill_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- The FIFO is show-ahead. avm_writedata always presents the head word.
- Push rule: a push occurs when sample_valid && (fill < FIFO_DEPTH || pop this cycle). Otherwise the sample is dropped and overflow sets.
- Capture is independent of enable.
- overflow: clear_ovf wins over a same-cycle drop, so overflow reads 0 on the next cycle.
- FSM states: IDLE, BURST.
- IDLE → BURST when enable && fill_level ≥ BURST_LEN. On entry: avm_write=1, avm_address=current pointer, beat counter=0.
- BURST, beat accepted (avm_write && !avm_waitrequest):
  - pop the FIFO and increment the beat counter.
  - On beat BURST_LEN−1 → IDLE, and the pointer advances by BURST_LEN·DATA_W/8.
- Ring wrap: if the advanced pointer reaches BASE_ADDR + RING_WORDS·DATA_W/8, it reloads BASE_ADDR and wrap_count increments.
- avm_address and avm_burstcount are held stable for the whole burst. avm_write stays high until the last beat is accepted; no idle beats within a burst.
- Deasserting enable mid-burst does not affect the current burst. The burst completes; no new burst starts.
- Reset mid-burst: the burst is abandoned and avm_write drops immediately.
  - Reset clears FIFO, pointer, overflow and wrap_count.
  - The SDRAM slave is reset by the same reset_reset_n.
- Simultaneous push and pop: fill_level is unchanged.

## Timing
- Reset values:
  - avm_write=0, avm_address=BASE_ADDR, avm_burstcount=BURST_LEN, avm_writedata=0
  - overflow=0, wrap_count=0, fill_level=0
  - FSM=IDLE
- A sample pushed at edge t is counted in fill_level after edge t. It is visible on avm_writedata after edge t if the FIFO was empty.
- Burst start: the condition true at edge t gives avm_write=1 after edge t, i.e. one cycle from fill_level reaching BURST_LEN.
- Burst duration: with no waitrequest, exactly BURST_LEN cycles.
- After the last beat, IDLE lasts at least one cycle before the next burst. Sustained throughput is BURST_LEN/(BURST_LEN+1) words per cycle.
- wrap_count and the pointer update on the edge that accepts the last beat.

## Structure
- Shared package ddr_writer_pkg: FSM state enum, byte-per-word and burst-byte-stride constants, and a function computing the ring end address.
- One sub-module: sync_fifo_fwft. It is parameterised width and depth, with show-ahead output, full/empty and a count output. No other hierarchy.

## Test plan
- Continuous samples 0,1,2,… with enable=1 and no waitrequest:
  - one burst at BASE_ADDR with data 0..7, then a burst at BASE_ADDR+32 with data 8..15;
  - avm_burstcount=8 on all beats.
- waitrequest held high for 5 cycles on beat 3:
  - address, burstcount and writedata (=3) are stable during the stall;
  - no FIFO pop; the burst then completes with 8 data words in order.
- enable=0 while 40 samples arrive:
  - samples 0..31 are held (fill_level=32); samples 32..39 are dropped and overflow=1;
  - clear_ovf gives overflow=0.
- RING_WORDS=16, 40 samples streamed:
  - addresses BASE, BASE+32, BASE, BASE+32, BASE;
  - wrap_count reaches 2 after the fourth burst.
- reset_reset_n low at beat 4 of a burst:
  - next cycle avm_write=0, fill_level=0 and avm_address=BASE_ADDR;
  - the next burst after reset carries post-reset samples only.
